fb_arbiter: RTL
===============

Name: fb_arbiter

Overview:
- Arbitrates the single port of the 400x240 RGB565 frame-buffer RAM between two requesters:
  - the LCD scan-out read path, which has absolute priority;
  - a pixel writer (drawing/loader engine), which uses a valid/ready handshake.
- Writes are buffered in a small FIFO and drained into cycles the display leaves idle.
- Sits between the scan-out addressing logic (row/column halving) and the frame-buffer RAM, in the NCLK domain.

Parameters:
- DEPTH, 4, write FIFO depth in entries (power of two, at least 2).
- RD_LAT, 1, RAM read latency in cycles, from the registered address to valid ram_rdata.

Ports:
- CLK  in  1  clock (NCLK domain)
- RST_N  in  1  asynchronous active-low reset
- rd_req  in  1  display read request, one pixel per asserted cycle
- rd_addr  in  17  display address {row[7:0], col[8:0]}
- rd_data  out  16  RGB565 pixel returned to the display
- rd_valid  out  1  rd_data valid
- wr_valid  in  1  writer has a pixel
- wr_ready  out  1  arbiter can accept a pixel
- wr_addr  in  17  writer address {row[7:0], col[8:0]}
- wr_data  in  16  RGB565 pixel to write
- drop_err  out  1  one-cycle pulse: an accepted write was out of range
- ram_addr  out  17  RAM address (registered)
- ram_wdata  out  16  RAM write data (registered)
- ram_we  out  1  RAM write enable (registered)
- ram_rdata  in  16  RAM read data
- starve_cnt  out  16  present only with FB_STARVE_CNT_EN

Behaviour:
- Reset (asynchronous, RST_N=0):
  - ram_addr=0, ram_wdata=0, ram_we=0.
  - rd_valid=0, rd_data=0, drop_err=0.
  - FIFO empty, so wr_ready=1 one cycle after RST_N is released.
  - Pending read tags cleared; FSM in IDLE.
- Reset mid-operation: all buffered writes are lost and in-flight reads never produce rd_valid.
- Write handshake:
  - A transfer occurs when wr_valid=1 and wr_ready=1.
  - wr_ready = !full. A pop in the same cycle does not admit a push into a full FIFO.
- Range check at acceptance:
  - col >= 400 or row >= 240: the write is accepted but not queued.
  - drop_err=1 in the following cycle.
- Grant FSM, with states IDLE, READ and WRITE; the state is the command registered this cycle:
  - rd_req=1 -> READ: ram_addr<=rd_addr, ram_we<=0.
  - Else FIFO not empty -> WRITE: pop head, ram_addr<=head.addr, ram_wdata<=head.data, ram_we<=1.
  - Else -> IDLE: ram_we<=0, ram_addr holds its value.
- Read response:
  - A READ grant in cycle N shifts a valid tag through a pipeline of RD_LAT+1 stages.
  - rd_valid=1 and rd_data=ram_rdata (captured registered) in cycle N+1+RD_LAT.
  - Latency is 2 cycles for RD_LAT=1.
  - Back-to-back rd_req gives one rd_valid per cycle, in order.
- Display is never stalled:
  - Writes progress only in cycles with rd_req=0 (blanking periods).
  - A full FIFO backpressures the writer only.
- Simultaneous push/pop (FIFO not full): both happen; occupancy is unchanged.
- FIFO pointers are log2(DEPTH)+1 bits wide, with a wrap bit; full/empty are derived from the pointer MSB compare.
- Read-after-write to the same address is not forwarded. The display may see the old pixel until the write drains.

Optional Feature:
- FB_STARVE_CNT_EN defined:
  - starve_cnt is a 16-bit saturating counter.
  - It increments each cycle with FIFO non-empty and rd_req=1, i.e. a write denied by the display.
  - It saturates at 0xFFFF and is cleared only by reset.
- Not defined: starve_cnt port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package fb_pkg:
  - H_RES=400, V_RES=240, ADDR_W=17, DATA_W=16, ROW_W=8, COL_W=9.
  - Grant-state encoding IDLE/READ/WRITE.
  - Write-entry struct {addr, data}.
- One sub-module, fb_wr_fifo:
  - DEPTH-entry synchronous FIFO with push/pop/full/empty.
  - Same asynchronous active-low reset.

Test Plan:
- Reset release, then wr_valid=1 with 3 writes to addresses {5,10},{5,11},{5,12}, data 0xF800/0x07E0/0x001F, rd_req=0 -> ram_we=1 on three consecutive cycles starting 2 cycles after the first accept, with matching ram_addr/ram_wdata; wr_ready stays 1.
- rd_req held 1 for 8 cycles while writer pushes 6 pixels -> wr_ready=0 after 4 accepts, ram_we=0 throughout, 8 rd_valid pulses in order 2 cycles after each rd_req; after rd_req drops, the 4 writes drain on 4 consecutive cycles.
- Write with col=400 (row 0), then one with row=240 (col 0) -> both accepted, drop_err pulses once for each, no ram_we issued.
- Interleaved pattern rd_req=1,0,1,0 with a full FIFO -> writes occupy exactly the rd_req=0 cycles, and rd_data matches the RAM model at 2-cycle latency.
- RST_N asserted with FIFO holding 3 entries and 2 reads in flight -> outputs reach their reset values immediately, no rd_valid and no ram_we afterwards, wr_ready=1 one cycle after release.
- With FB_STARVE_CNT_EN: 1 queued write and rd_req=1 for 70000 cycles -> starve_cnt=0xFFFF (saturated); the write completes on the first rd_req=0 cycle.

Source files
------------

// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - frame-buffer arbiter shared geometry, grant states and write-entry type
package fb_pkg;

  localparam int H_RES  = 400;
  localparam int V_RES  = 240;
  localparam int ADDR_W = 17;
  localparam int DATA_W = 16;
  localparam int ROW_W  = 8;
  localparam int COL_W  = 9;

  // Command registered toward the RAM in the current cycle
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } gnt_state_t;

  // One buffered pixel write
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_entry_t;

  // Address is {row, col}; anything outside the visible 400x240 area is rejected
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
    return (a[COL_W-1:0] < COL_W'(H_RES)) && (a[ADDR_W-1:COL_W] < ROW_W'(V_RES));
  endfunction

endpackage

// File: rtl/fb_wr_fifo.sv
// rtl/fb_wr_fifo.sv - DEPTH-entry synchronous write FIFO with wrap-bit pointers
module fb_wr_fifo
  import fb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  wr_entry_t push_entry,
  input  logic      pop,
  output wr_entry_t head,
  output logic      full,
  output logic      empty
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  wr_entry_t          mem [DEPTH];
  logic [PTR_W-1:0]   wptr;
  logic [PTR_W-1:0]   rptr;
  logic               do_push;
  logic               do_pop;

  // A full FIFO never takes a push, even when a pop frees a slot this cycle
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign empty = (wptr == rptr);
  assign full  = (wptr[PTR_W-1] != rptr[PTR_W-1]) &&
                 (wptr[IDX_W-1:0] == rptr[IDX_W-1:0]);
  assign head  = mem[rptr[IDX_W-1:0]];

  // Entry storage; contents are meaningless while the pointers say empty
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr[IDX_W-1:0]] <= push_entry;
    end
  end

  // Pointer update; reset discards every buffered entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + PTR_W'(1);
      if (do_pop)  rptr <= rptr + PTR_W'(1);
    end
  end

endmodule

// File: rtl/fb_arbiter.sv
// rtl/fb_arbiter.sv - frame-buffer RAM port arbiter, display reads first; FB_STARVE_CNT_EN adds starve_cnt
module fb_arbiter
  import fb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int RD_LAT = 1
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        rd_req,
  input  logic [16:0] rd_addr,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [16:0] wr_addr,
  input  logic [15:0] wr_data,
  output logic        drop_err,
  output logic [16:0] ram_addr,
  output logic [15:0] ram_wdata,
  output logic        ram_we,
  input  logic [15:0] ram_rdata
`ifdef FB_STARVE_CNT_EN
  ,
  output logic [15:0] starve_cnt
`endif
);

  gnt_state_t       state;
  wr_entry_t        fifo_head;
  wr_entry_t        push_entry;
  logic             fifo_full;
  logic             fifo_empty;
  logic             accept;
  logic             in_range;
  logic             push;
  logic             pop;
  logic             st_read;
  logic [RD_LAT-1:0] tag_q;
  logic [RD_LAT:0]  tag_vec;

  assign wr_ready   = !fifo_full;
  assign accept     = wr_valid && wr_ready;
  assign in_range   = addr_in_range(wr_addr);
  assign push       = accept && in_range;
  // The display owns every cycle it asks for; writes only fill the gaps
  assign pop        = !rd_req && !fifo_empty;
  assign push_entry = '{addr: wr_addr, data: wr_data};

  fb_wr_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (CLK),
    .rst_n      (RST_N),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (fifo_head),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  // Grant FSM: registers the RAM command chosen for this cycle
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_we    <= 1'b0;
    end else if (rd_req) begin
      state    <= READ;
      ram_addr <= rd_addr;
      ram_we   <= 1'b0;
    end else if (!fifo_empty) begin
      state     <= WRITE;
      ram_addr  <= fifo_head.addr;
      ram_wdata <= fifo_head.data;
      ram_we    <= 1'b1;
    end else begin
      state  <= IDLE;
      ram_we <= 1'b0;
    end
  end

  // Stage 0 of the read tag is the READ state itself; later stages follow the RAM latency
  assign st_read = (state == READ);
  assign tag_vec = {tag_q, st_read};
  assign rd_valid = tag_vec[RD_LAT];

  // Read tag pipeline and return-data capture
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tag_q   <= '0;
      rd_data <= '0;
    end else begin
      tag_q <= tag_vec[RD_LAT-1:0];
      if (tag_vec[RD_LAT-1]) begin
        rd_data <= ram_rdata;
      end
    end
  end

  // Out-of-range writes are swallowed and flagged one cycle later
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      drop_err <= 1'b0;
    end else begin
      drop_err <= accept && !in_range;
    end
  end

`ifdef FB_STARVE_CNT_EN
  // Counts cycles where a buffered write was held off by the display
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      starve_cnt <= '0;
    end else if (!fifo_empty && rd_req && (starve_cnt != 16'hFFFF)) begin
      starve_cnt <= starve_cnt + 16'd1;
    end
  end
`endif

endmodule
